// File: rtl/fpgaminer_pkg.sv
// fpgaminer_pkg: shared widths, payload lengths and loader state encoding.
package fpgaminer_pkg;
  localparam int MIDSTATE_W = 256;
  localparam int WORK_W = 96;
  localparam int NONCE_W = 32;
  localparam int PAYLOAD_LEN = 52;
  localparam int PAYLOAD_LEN_CK = 53;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  typedef enum logic [1:0] {HUNT, PAYLOAD, COMMIT} state_t;
endpackage

// File: rtl/work_loader.sv
// work_loader: assembles sync-framed job bytes into midstate/work/nonce-range registers.
// Define WORK_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module work_loader import fpgaminer_pkg::*; #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic hash_clk,
  input  logic reset,
  input  logic [7:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic [MIDSTATE_W-1:0] midstate,
  output logic [WORK_W-1:0] work_data,
  output logic [NONCE_W-1:0] nonce_min,
  output logic [NONCE_W-1:0] nonce_max,
  output logic miner_reset,
  output logic [7:0] frame_err_cnt
);
`ifdef WORK_LOADER_CHECKSUM_EN
  localparam int LEN = PAYLOAD_LEN_CK;
`else
  localparam int LEN = PAYLOAD_LEN;
`endif
  state_t state;
  logic [5:0] idx;
  logic [31:0] idle;
  logic [415:0] frame_q;
  logic [7:0] xsum;
  logic accept, last, ok, timeout;
  logic [415:0] frame_next;
  logic [7:0] err_next;
  assign in_ready = state != COMMIT;
  assign accept = in_valid && in_ready;
  assign last = idx == 6'(LEN - 1);
  assign frame_next = {frame_q[407:0], in_data};
  assign timeout = TIMEOUT_CYCLES != 0 && idle + 1 == TIMEOUT_CYCLES;
  assign err_next = frame_err_cnt + {7'd0, frame_err_cnt != 8'hFF};
`ifdef WORK_LOADER_CHECKSUM_EN
  // the checksum byte is not shifted, so the frame is already complete
  assign ok = frame_q[63:32] <= frame_q[31:0] && in_data == xsum;
`else
  assign ok = frame_next[63:32] <= frame_next[31:0];
`endif
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
      idx <= '0;
      idle <= '0;
      frame_q <= '0;
      xsum <= '0;
      midstate <= '0;
      work_data <= '0;
      nonce_min <= '0;
      nonce_max <= '0;
      miner_reset <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      miner_reset <= state == COMMIT;
      case (state)
        HUNT:
          if (accept && in_data == SYNC_BYTE) begin
            state <= PAYLOAD;
            idx <= '0;
            idle <= '0;
            xsum <= '0;
          end
        PAYLOAD:
          if (accept) begin
            idle <= '0;
            idx <= idx + 6'd1;
            if (idx < 6'(PAYLOAD_LEN)) begin
              frame_q <= frame_next;
              xsum <= xsum ^ in_data;
            end
            if (last) begin
              state <= ok ? COMMIT : HUNT;
              if (!ok) frame_err_cnt <= err_next;
            end
          end else if (timeout) begin
            state <= HUNT;
            frame_err_cnt <= err_next;
          end else
            idle <= idle + 32'd1;
        COMMIT: begin
          state <= HUNT;
          midstate <= frame_q[415:160];
          work_data <= frame_q[159:64];
          nonce_min <= frame_q[63:32];
          nonce_max <= frame_q[31:0];
        end
        default: state <= HUNT;
      endcase
    end
  end
endmodule
